// File: rtl/axi_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_read_arbiter_pkg
// Shared state encoding and requester ids for the imem read arbiter.
// Rev    : 1.0
// ============================================================================
package axi_read_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_AR   = 2'd1;
  localparam arb_state_t ARB_R    = 2'd2;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_read_if.sv
`default_nettype none
// ============================================================================
// Module : axi_read_if
// AXI read address / read data channel bundle with master and slave views.
// Rev    : 1.0
// ============================================================================
interface axi_read_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (output araddr, arlen, arvalid, rready,
                  input  arready, rdata, rresp, rlast, rvalid);
  modport slave  (input  araddr, arlen, arvalid, rready,
                  output arready, rdata, rresp, rlast, rvalid);
endinterface
`default_nettype wire

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Two-way round-robin grant; on a tie the requester that did not win last time wins.
// Rev    : 1.0
// ============================================================================
module rr_arbiter2
  import axi_read_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  logic w_last_dcache;

  assign w_last_dcache = (last_grant == REQ_DCACHE);
  assign gnt[0] = req[0] & (~req[1] |  w_last_dcache);
  assign gnt[1] = req[1] & (~req[0] | ~w_last_dcache);

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_read_arbiter
// Shares one imem AXI read port between icache (m0) and dcache (m1) fills.
// Rev    : 1.0
// ============================================================================
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_read_if.slave   m0_axi,
  axi_read_if.slave   m1_axi,
  axi_read_if.master  s_axi,
  output logic        owner_o,
  output logic        busy_o,
  output logic        err_o
);

  arb_state_t            r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [LEN_WIDTH-1:0]  r_arlen;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic                  r_err;

  logic [1:0]            w_gnt_raw;
  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_in_r;
  logic                  w_last_cnt;
  logic                  w_beat;
  logic                  w_rlast;
  logic [DATA_WIDTH-1:0] w_rdata;

  rr_arbiter2 u_rr (
    .req        ({m1_axi.arvalid, m0_axi.arvalid}),
    .last_grant (r_last_grant),
    .gnt        (w_gnt_raw)
  );

  // Grants are masked while reset is asserted so arready stays low during reset.
  assign w_idle     = (r_state == ARB_IDLE) & rst_n;
  assign w_gnt      = w_gnt_raw & {2{w_idle}};
  assign w_in_r     = (r_state == ARB_R);
  assign w_last_cnt = (r_beat_cnt == r_arlen);
  assign w_beat     = w_in_r & s_axi.rvalid & s_axi.rready;
  assign w_rlast    = s_axi.rlast | w_last_cnt;
  assign w_rdata    = s_axi.rdata;

  assign m0_axi.arready = w_gnt[0];
  assign m1_axi.arready = w_gnt[1];

  assign s_axi.arvalid = (r_state == ARB_AR);
  assign s_axi.araddr  = r_araddr;
  assign s_axi.arlen   = r_arlen;
  assign s_axi.rready  = w_in_r & (r_owner ? m1_axi.rready : m0_axi.rready);

  assign m0_axi.rvalid = w_in_r & ~r_owner & s_axi.rvalid;
  assign m1_axi.rvalid = w_in_r &  r_owner & s_axi.rvalid;
  assign m0_axi.rlast  = w_in_r & ~r_owner & w_rlast;
  assign m1_axi.rlast  = w_in_r &  r_owner & w_rlast;
  assign m0_axi.rdata  = w_rdata;
  assign m1_axi.rdata  = w_rdata;
  assign m0_axi.rresp  = s_axi.rresp;
  assign m1_axi.rresp  = s_axi.rresp;

  assign owner_o = r_owner;
  assign busy_o  = (r_state != ARB_IDLE);
  assign err_o   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= REQ_DCACHE;
      r_owner      <= REQ_ICACHE;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_gnt) begin
            r_araddr     <= w_gnt[1] ? m1_axi.araddr : m0_axi.araddr;
            r_arlen      <= w_gnt[1] ? m1_axi.arlen  : m0_axi.arlen;
            r_owner      <= w_gnt[1];
            r_last_grant <= w_gnt[1];
            r_beat_cnt   <= '0;
            r_state      <= ARB_AR;
          end
        end
        ARB_AR: begin
          if (s_axi.arready) r_state <= ARB_R;
        end
        ARB_R: begin
          if (w_beat) begin
            // Early rlast or a missing rlast on the expected final beat both flag a length error.
            if (s_axi.rlast != w_last_cnt) r_err <= 1'b1;
            if (w_rlast) r_state    <= ARB_IDLE;
            else         r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_read_arbiter
// Directed vector bench for axi_read_arbiter with an inline imem responder.
// Rev    : 1.0
// ============================================================================
module tb_axi_read_arbiter;

  logic clk;
  logic rst_n;
  logic owner_o, busy_o, err_o;

  axi_read_if m0_if ();
  axi_read_if m1_if ();
  axi_read_if s_if ();

  axi_read_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0_axi  (m0_if),
    .m1_axi  (m1_if),
    .s_axi   (s_if),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    logic [1:0]  gnt;
    int          mode;   // 0 normal, 1 early rlast, 2 missing rlast
    int          nb;     // beats returned by imem
    int          stall;  // beat index held off by rready=0 for 3 cycles, -1 none
    logic        err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic own_rvalid(input int own);
    return (own != 0) ? m1_if.rvalid : m0_if.rvalid;
  endfunction

  function automatic logic oth_rvalid(input int own);
    return (own != 0) ? m0_if.rvalid : m1_if.rvalid;
  endfunction

  function automatic logic [31:0] own_rdata(input int own);
    return (own != 0) ? m1_if.rdata : m0_if.rdata;
  endfunction

  function automatic logic own_rlast(input int own);
    return (own != 0) ? m1_if.rlast : m0_if.rlast;
  endfunction

  task automatic set_rready(input int own, input logic v);
    if (own != 0) m1_if.rready = v;
    else          m0_if.rready = v;
  endtask

  // Checks arready pair, then completes the handshake and drops the winner's arvalid.
  task automatic grant(input logic [1:0] exp, input bit wait_first);
    if (wait_first) #4;
    chk("grant", {30'd0, m1_if.arready, m0_if.arready}, {30'd0, exp});
    @(posedge clk); #1;
    if (exp[0]) m0_if.arvalid = 1'b0;
    if (exp[1]) m1_if.arvalid = 1'b0;
  endtask

  // Entered 1 time unit after the grant edge; returns mid-cycle in the following IDLE.
  task automatic serve(input int own, input logic [31:0] addr, input logic [7:0] len,
                       input int mode, input int nb, input int stall);
    #4;
    chk("ar_valid", s_if.arvalid, 1);
    chk("ar_addr", s_if.araddr, addr);
    chk("ar_len", s_if.arlen, len);
    chk("owner", owner_o, own);
    chk("busy_ar", busy_o, 1);
    chk("ar_block", {30'd0, m1_if.arready, m0_if.arready}, 0);
    s_if.arready = 1'b1;
    @(posedge clk); #1;
    s_if.arready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      s_if.rvalid = 1'b1;
      s_if.rdata  = addr + 32'(b);
      s_if.rresp  = 2'b00;
      s_if.rlast  = (mode == 2) ? 1'b0 : (b == nb - 1);
      if (b == stall) begin
        set_rready(own, 1'b0);
        for (int k = 0; k < 3; k++) begin
          #4;
          chk("stall_rready", s_if.rready, 0);
          chk("stall_rvalid", own_rvalid(own), 1);
          chk("stall_rdata", own_rdata(own), addr + 32'(b));
          @(posedge clk); #1;
        end
        set_rready(own, 1'b1);
      end
      #4;
      chk("beat_valid", own_rvalid(own), 1);
      chk("beat_data", own_rdata(own), addr + 32'(b));
      chk("beat_last", own_rlast(own), (b == nb - 1) ? 1 : 0);
      chk("other_rvalid", oth_rvalid(own), 0);
      chk("s_rready", s_if.rready, 1);
      @(posedge clk); #1;
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
    #4;
    chk("busy_idle", busy_o, 0);
    chk("beat_cnt", {24'd0, dut.r_beat_cnt}, nb - 1);
    chk("owner_hold", owner_o, own);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{req0:1, req1:0, a0:32'h0000_0108, l0:8'd3, a1:32'h0, l1:8'd0, gnt:2'b01, mode:0, nb:4, stall:-1, err:0};
    vt[1] = '{req0:0, req1:1, a0:32'h0, l0:8'd0, a1:32'h0000_2000, l1:8'd0, gnt:2'b10, mode:0, nb:1, stall:-1, err:0};
    vt[2] = '{req0:1, req1:1, a0:32'h0000_0300, l0:8'd1, a1:32'h0000_0400, l1:8'd2, gnt:2'b01, mode:0, nb:2, stall:-1, err:0};
    vt[3] = '{req0:1, req1:1, a0:32'h0000_0500, l0:8'd2, a1:32'h0000_0600, l1:8'd1, gnt:2'b10, mode:0, nb:2, stall:-1, err:0};
    vt[4] = '{req0:1, req1:0, a0:32'h0000_0700, l0:8'd3, a1:32'h0, l1:8'd0, gnt:2'b01, mode:0, nb:4, stall:1, err:0};
    vt[5] = '{req0:0, req1:1, a0:32'h0, l0:8'd0, a1:32'h0000_0800, l1:8'd3, gnt:2'b10, mode:0, nb:4, stall:2, err:0};
    vt[6] = '{req0:1, req1:0, a0:32'h0000_0900, l0:8'd3, a1:32'h0, l1:8'd0, gnt:2'b01, mode:1, nb:3, stall:-1, err:1};
    vt[7] = '{req0:0, req1:1, a0:32'h0, l0:8'd0, a1:32'h0000_0A00, l1:8'd2, gnt:2'b10, mode:0, nb:3, stall:-1, err:1};
    vt[8] = '{req0:1, req1:0, a0:32'h0000_0B00, l0:8'd1, a1:32'h0, l1:8'd0, gnt:2'b01, mode:2, nb:2, stall:-1, err:1};

    rst_n = 1'b0;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0; m0_if.arlen = 8'd0; m0_if.rready = 1'b1;
    m1_if.arvalid = 1'b0; m1_if.araddr = 32'h0; m1_if.arlen = 8'd0; m1_if.rready = 1'b1;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.rresp = 2'b00; s_if.rlast = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_arready", m0_if.arready, 0);
    chk("rst_s_arvalid", s_if.arvalid, 0);
    chk("rst_s_rready", s_if.rready, 0);
    chk("rst_s_araddr", s_if.araddr, 0);
    chk("rst_s_arlen", s_if.arlen, 0);
    m0_if.arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous requests after reset: m0 first, m1 held and granted after one IDLE cycle.
    @(posedge clk); #1;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h40; m0_if.arlen = 8'd1;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h80; m1_if.arlen = 8'd2;
    grant(2'b01, 1'b1);
    serve(0, 32'h40, 8'd1, 0, 2, -1);
    grant(2'b10, 1'b0);
    serve(1, 32'h80, 8'd2, 0, 3, -1);

    // Back-to-back contention: m0, m1, m0, m1.
    @(posedge clk); #1;
    m0_if.araddr = 32'h1000; m0_if.arlen = 8'd1;
    m1_if.araddr = 32'h2000; m1_if.arlen = 8'd0;
    m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grant((i % 2 != 0) ? 2'b10 : 2'b01, i == 0);
      if (i % 2 != 0) serve(1, 32'h2000, 8'd0, 0, 1, -1);
      else            serve(0, 32'h1000, 8'd1, 0, 2, -1);
      if (i < 2) begin
        if (i % 2 != 0) m1_if.arvalid = 1'b1;
        else            m0_if.arvalid = 1'b1;
        #1;
      end
    end

    for (int i = 0; i < 9; i++) begin
      int own;
      @(posedge clk); #1;
      m0_if.arvalid = vt[i].req0; m0_if.araddr = vt[i].a0; m0_if.arlen = vt[i].l0;
      m1_if.arvalid = vt[i].req1; m1_if.araddr = vt[i].a1; m1_if.arlen = vt[i].l1;
      grant(vt[i].gnt, 1'b1);
      m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
      own = vt[i].gnt[1] ? 1 : 0;
      serve(own, (own != 0) ? vt[i].a1 : vt[i].a0, (own != 0) ? vt[i].l1 : vt[i].l0,
            vt[i].mode, vt[i].nb, vt[i].stall);
      chk("err_flag", err_o, vt[i].err);
    end

    // Reset during the second beat of a burst.
    @(posedge clk); #1;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'hC00; m0_if.arlen = 8'd3;
    grant(2'b01, 1'b1);
    #4; s_if.arready = 1'b1;
    @(posedge clk); #1;
    s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'hC00; s_if.rlast = 1'b0;
    @(posedge clk); #1;
    s_if.rdata = 32'hC01;
    #2;
    chk("pre_rst_rvalid", m0_if.rvalid, 1);
    rst_n = 1'b0;
    m0_if.arvalid = 1'b1;
    #1;
    chk("mid_rst_rvalid", m0_if.rvalid, 0);
    chk("mid_rst_arready", m0_if.arready, 0);
    chk("mid_rst_s_arvalid", s_if.arvalid, 0);
    chk("mid_rst_s_rready", s_if.rready, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_owner", owner_o, 0);
    s_if.rvalid = 1'b0;
    m0_if.arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #4;
    chk("post_rst_busy", busy_o, 0);

    // Tie right after reset again goes to m0.
    @(posedge clk); #1;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'hD00; m0_if.arlen = 8'd0;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'hE00; m1_if.arlen = 8'd0;
    grant(2'b01, 1'b1);
    m1_if.arvalid = 1'b0;
    serve(0, 32'hD00, 8'd0, 0, 1, -1);
    chk("final_err", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
